// File: rtl/rt_sched_pkg.sv
// -----------------------------------------------------------------------------
// rt_sched_pkg
// Shared definitions for the ray-tracer frame scheduler: scheduler state
// encoding, default parameter values, bus data width and the pixel-coordinate
// width. No ports.
// -----------------------------------------------------------------------------
package rt_sched_pkg;

    localparam int SCENE_WORDS_DEF     = 27;
    localparam int IMG_W_DEF           = 32;
    localparam int IMG_H_DEF           = 32;
    localparam int MAX_OUTSTANDING_DEF = 4;

    localparam int DATA_W  = 32;
    localparam int COORD_W = 16;

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_RENDER = 2'd1,
        ST_DONE   = 2'd2
    } sched_state_e;

    typedef logic [COORD_W-1:0] coord_t;
    typedef logic [DATA_W-1:0]  word_t;

endpackage

// File: rtl/rt_scheduler_if.sv
// -----------------------------------------------------------------------------
// rt_scheduler_if
// Bundles the four handshake channels around the scheduler:
//   s_axis_*  configuration stream into the scheduler
//   m_axis_*  pixel stream out of the scheduler
//   req_*     pixel request from the scheduler to the renderer core
//   rsp_*     in-order pixel result from the core
// Modports:
//   master  the scheduler's view
//   slave   the environment's view (config source, pixel sink, core)
// -----------------------------------------------------------------------------
interface rt_scheduler_if;
    import rt_sched_pkg::*;

    logic   s_axis_tvalid;
    logic   s_axis_tready;
    word_t  s_axis_tdata;
    logic   s_axis_tlast;

    logic   m_axis_tvalid;
    logic   m_axis_tready;
    word_t  m_axis_tdata;
    logic   m_axis_tlast;

    logic   req_valid;
    logic   req_ready;
    coord_t req_x;
    coord_t req_y;

    logic   rsp_valid;
    logic   rsp_ready;
    word_t  rsp_data;

    modport master (
        input  s_axis_tvalid, s_axis_tdata, s_axis_tlast,
        output s_axis_tready,
        output m_axis_tvalid, m_axis_tdata, m_axis_tlast,
        input  m_axis_tready,
        output req_valid, req_x, req_y,
        input  req_ready,
        input  rsp_valid, rsp_data,
        output rsp_ready
    );

    modport slave (
        output s_axis_tvalid, s_axis_tdata, s_axis_tlast,
        input  s_axis_tready,
        input  m_axis_tvalid, m_axis_tdata, m_axis_tlast,
        output m_axis_tready,
        input  req_valid, req_x, req_y,
        output req_ready,
        output rsp_valid, rsp_data,
        input  rsp_ready
    );

endinterface

// File: rtl/rt_raster_counter.sv
// -----------------------------------------------------------------------------
// rt_raster_counter
// Raster-order pixel coordinate generator: x runs 0..IMG_W-1, then y steps.
// Ports:
//   aclk, reset  clock and synchronous active-high reset
//   clear        force the position back to (0,0)
//   advance      step to the next pixel (wraps after the last one)
//   x, y         current pixel coordinate
//   last         high while the position is (IMG_W-1, IMG_H-1)
// -----------------------------------------------------------------------------
module rt_raster_counter
    import rt_sched_pkg::*;
#(
    parameter int IMG_W = IMG_W_DEF,
    parameter int IMG_H = IMG_H_DEF
) (
    input  logic   aclk,
    input  logic   reset,
    input  logic   clear,
    input  logic   advance,
    output coord_t x,
    output coord_t y,
    output logic   last
);

    localparam coord_t X_MAX = COORD_W'(IMG_W - 1);
    localparam coord_t Y_MAX = COORD_W'(IMG_H - 1);

    coord_t x_q, x_d;
    coord_t y_q, y_d;

    // NOTE: every variable written in a combinational block gets a default
    // first; a path that skipped an assignment would infer a latch.
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (clear) begin
            x_d = '0;
            y_d = '0;
        end else if (advance) begin
            if (x_q == X_MAX) begin
                x_d = '0;
                y_d = (y_q == Y_MAX) ? '0 : y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of process evaluation order.
    always_ff @(posedge aclk) begin
        if (reset) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign x    = x_q;
    assign y    = y_q;
    assign last = (x_q == X_MAX) && (y_q == Y_MAX);

endmodule

// File: rtl/rt_scheduler.sv
// -----------------------------------------------------------------------------
// rt_scheduler
// Frame scheduler for a ray-tracing core. Loads a scene configuration from a
// stream, then issues one request per pixel in raster order (bounded by
// MAX_OUTSTANDING in flight) and forwards the in-order results to the pixel
// stream, marking the final pixel with tlast.
//
// Ports:
//   aclk, reset   clock and synchronous active-high reset
//   bus           handshake channels (rt_scheduler_if.master)
//   cfg_data      committed configuration, word i at [32i+31:32i]
//   busy          high while rendering or finishing a frame
//   frame_done    one-cycle pulse after the last pixel leaves
//   cfg_err       one-cycle pulse, the cycle after a payload ended early
//   perf_cycles   render cycle count of the current/last frame
//
// Build option: define RT_SCHED_PERF_EN to build the render cycle counter;
// otherwise perf_cycles is tied to zero.
// -----------------------------------------------------------------------------
module rt_scheduler
    import rt_sched_pkg::*;
#(
    parameter int SCENE_WORDS     = SCENE_WORDS_DEF,
    parameter int IMG_W           = IMG_W_DEF,
    parameter int IMG_H           = IMG_H_DEF,
    parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEF
) (
    input  logic                      aclk,
    input  logic                      reset,
    rt_scheduler_if.master            bus,
    output logic [SCENE_WORDS*32-1:0] cfg_data,
    output logic                      busy,
    output logic                      frame_done,
    output logic                      cfg_err,
    output logic [31:0]               perf_cycles
);

    localparam int TOTAL  = IMG_W * IMG_H;
    localparam int WIDX_W = $clog2(SCENE_WORDS + 1);
    localparam int CNT_W  = $clog2(TOTAL + 1);
    localparam int OUT_W  = $clog2(MAX_OUTSTANDING + 1);

    localparam logic [WIDX_W-1:0] LAST_IDX  = WIDX_W'(SCENE_WORDS - 1);
    // widx parks here once the payload is full; extra beats are ignored.
    localparam logic [WIDX_W-1:0] OVF_IDX   = WIDX_W'(SCENE_WORDS);
    localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(TOTAL - 1);
    localparam logic [OUT_W-1:0]  OUT_MAX   = OUT_W'(MAX_OUTSTANDING);

    typedef logic [SCENE_WORDS-1:0][DATA_W-1:0] scene_t;

    sched_state_e      state_q, state_d;
    logic [WIDX_W-1:0] widx_q, widx_d;
    scene_t            stage_q, stage_d;
    scene_t            cfg_q, cfg_d;
    logic              cfg_err_q, cfg_err_d;
    logic              issue_done_q, issue_done_d;
    logic [OUT_W-1:0]  outst_q, outst_d;
    logic [CNT_W-1:0]  recv_q, recv_d;

    logic   in_render;
    logic   s_ready, req_valid, m_valid, m_last, r_ready;
    logic   cfg_hs, req_hs, out_hs;
    coord_t rc_x, rc_y;
    logic   rc_last;

    // -------------------------------------------------------------------------
    // Handshake outputs. The result path is a pure combinational pass-through
    // gated by the RENDER state, so nothing is forwarded outside a frame.
    // -------------------------------------------------------------------------
    assign in_render = (state_q == ST_RENDER);
    assign s_ready   = (state_q == ST_LOAD);
    assign req_valid = in_render && !issue_done_q && (outst_q < OUT_MAX);
    assign m_valid   = in_render && bus.rsp_valid;
    assign r_ready   = in_render && bus.m_axis_tready;
    assign m_last    = m_valid && (recv_q == LAST_BEAT);

    assign cfg_hs = s_ready && bus.s_axis_tvalid;
    assign req_hs = req_valid && bus.req_ready;
    assign out_hs = m_valid && bus.m_axis_tready;

    assign bus.s_axis_tready = s_ready;
    assign bus.req_valid     = req_valid;
    assign bus.req_x         = rc_x;
    assign bus.req_y         = rc_y;
    assign bus.m_axis_tvalid = m_valid;
    assign bus.m_axis_tdata  = bus.rsp_data;
    assign bus.m_axis_tlast  = m_last;
    assign bus.rsp_ready     = r_ready;

    assign cfg_data   = cfg_q;
    assign busy       = (state_q != ST_LOAD);
    assign frame_done = (state_q == ST_DONE);
    assign cfg_err    = cfg_err_q;

    // Held at (0,0) outside RENDER so each frame starts at the first pixel.
    rt_raster_counter #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H)
    ) u_raster (
        .aclk    (aclk),
        .reset   (reset),
        .clear   (!in_render),
        .advance (req_hs),
        .x       (rc_x),
        .y       (rc_y),
        .last    (rc_last)
    );

    // -------------------------------------------------------------------------
    // Next-state and datapath
    // -------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        widx_d       = widx_q;
        stage_d      = stage_q;
        cfg_d        = cfg_q;
        cfg_err_d    = 1'b0;
        issue_done_d = issue_done_q;
        outst_d      = outst_q;
        recv_d       = recv_q;

        unique case (state_q)
            ST_LOAD: begin
                issue_done_d = 1'b0;
                outst_d      = '0;
                recv_d       = '0;
                if (cfg_hs) begin
                    // Beats land in a staging copy; cfg_data only changes on
                    // a complete payload, so a truncated one leaves it intact.
                    if (widx_q < OVF_IDX) begin
                        for (int i = 0; i < SCENE_WORDS; i++) begin
                            if (widx_q == WIDX_W'(i)) begin
                                stage_d[i] = bus.s_axis_tdata;
                            end
                        end
                    end
                    if (bus.s_axis_tlast) begin
                        widx_d = '0;
                        if (widx_q >= LAST_IDX) begin
                            cfg_d   = stage_d;
                            state_d = ST_RENDER;
                        end else begin
                            cfg_err_d = 1'b1;
                        end
                    end else if (widx_q != OVF_IDX) begin
                        widx_d = widx_q + 1'b1;
                    end
                end
            end

            ST_RENDER: begin
                // Once the last coordinate has been handed out, no more
                // requests are issued for this frame.
                if (req_hs && rc_last) begin
                    issue_done_d = 1'b1;
                end
                case ({req_hs, out_hs})
                    2'b10: outst_d = outst_q + 1'b1;
                    // A result with nothing outstanding is a core protocol
                    // error; the count stays at zero rather than wrapping.
                    2'b01: if (outst_q != '0) outst_d = outst_q - 1'b1;
                    default: ;
                endcase
                if (out_hs) begin
                    recv_d = recv_q + 1'b1;
                    if (recv_q == LAST_BEAT) begin
                        state_d = ST_DONE;
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_LOAD;
            end

            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    always_ff @(posedge aclk) begin
        if (reset) begin
            state_q      <= ST_LOAD;
            widx_q       <= '0;
            cfg_q        <= '0;
            cfg_err_q    <= 1'b0;
            issue_done_q <= 1'b0;
            outst_q      <= '0;
            recv_q       <= '0;
        end else begin
            state_q      <= state_d;
            widx_q       <= widx_d;
            cfg_q        <= cfg_d;
            cfg_err_q    <= cfg_err_d;
            issue_done_q <= issue_done_d;
            outst_q      <= outst_d;
            recv_q       <= recv_d;
        end
    end

    // NOTE: the staging buffer is deliberately not reset: a payload only
    // commits after every word of it was rewritten since the last widx clear,
    // so stale contents can never reach cfg_data.
    always_ff @(posedge aclk) begin
        stage_q <= stage_d;
    end

    // -------------------------------------------------------------------------
    // Render cycle counter
    // -------------------------------------------------------------------------
`ifdef RT_SCHED_PERF_EN
    logic [31:0] perf_q, perf_d;

    always_comb begin
        perf_d = perf_q;
        if ((state_q == ST_LOAD) && (state_d == ST_RENDER)) begin
            perf_d = '0;
        end else if (in_render && (perf_q != '1)) begin
            perf_d = perf_q + 1'b1;
        end
    end

    always_ff @(posedge aclk) begin
        if (reset) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_cycles = perf_q;
`else
    assign perf_cycles = '0;
`endif

endmodule

// File: tb/tb_rt_scheduler.sv
// -----------------------------------------------------------------------------
// tb_rt_scheduler
// Self-checking bench for rt_scheduler. A behavioural model tracks the frame
// phase, the payload of the current configuration packet, the number of
// issued / returned pixels and the expected raster value of every output beat.
// The renderer core is a queue with a fixed per-frame latency that answers
// each request with (y<<16)|x.
// -----------------------------------------------------------------------------
module tb_rt_scheduler;
    import rt_sched_pkg::*;

    localparam int SW    = 27;
    localparam int W     = 32;
    localparam int H     = 32;
    localparam int MAXO  = 4;
    localparam int TOTAL = W * H;

    typedef enum int {PH_LOAD, PH_RENDER, PH_DONE} phase_e;

    typedef struct {
        logic [31:0] data;
        logic        last;
    } beat_t;

    typedef struct {
        logic [31:0] data;
        int          due;
    } core_t;

    logic              aclk = 1'b0;
    logic              reset;
    logic [SW*32-1:0]  cfg_data;
    logic              busy;
    logic              frame_done;
    logic              cfg_err;
    logic [31:0]       perf_cycles;

    rt_scheduler_if bus ();

    rt_scheduler #(
        .SCENE_WORDS     (SW),
        .IMG_W           (W),
        .IMG_H           (H),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .aclk        (aclk),
        .reset       (reset),
        .bus         (bus),
        .cfg_data    (cfg_data),
        .busy        (busy),
        .frame_done  (frame_done),
        .cfg_err     (cfg_err),
        .perf_cycles (perf_cycles)
    );

    always #5 aclk = ~aclk;

    // ---------------- bench state ----------------
    int vectors     = 0;
    int miscompares = 0;

    phase_e           phase;
    int               issued, received, outst, max_outst, render_cycles, cyc;
    bit               err_due;
    logic [31:0]      frame_beats[$];
    beat_t            cfg_src[$];
    core_t            core_q[$];
    logic [SW*32-1:0] ref_cfg;
    int               core_lat;
    bit               m_rand, r_rand;
    int               cfg_err_pulses, done_pulses;
    logic [31:0]      last_beat_data;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] raster(input int k);
        return (32'(k / W) << 16) | 32'(k % W);
    endfunction

    function automatic logic [31:0] word_of(input logic [SW*32-1:0] v, input int i);
        return v[i*32 +: 32];
    endfunction

    task automatic model_clear();
        phase    = PH_LOAD;
        issued   = 0;
        received = 0;
        outst    = 0;
        err_due  = 1'b0;
        ref_cfg  = '0;
        frame_beats.delete();
        cfg_src.delete();
    endtask

    // One clock cycle: drive at the falling edge, compare 1 time unit later,
    // then advance the model to what the next rising edge commits.
    task automatic step();
        bit     s_hs, req_hs, out_hs;
        bit     exp_s_ready, exp_req_valid, exp_mvalid, err_next;
        phase_e next;
        core_t  item;

        @(negedge aclk);
        if (cfg_src.size() > 0) begin
            bus.s_axis_tvalid = 1'b1;
            bus.s_axis_tdata  = cfg_src[0].data;
            bus.s_axis_tlast  = cfg_src[0].last;
        end else begin
            bus.s_axis_tvalid = 1'b0;
            bus.s_axis_tdata  = '0;
            bus.s_axis_tlast  = 1'b0;
        end
        if (core_q.size() > 0) begin
            bus.rsp_valid = (core_q[0].due <= cyc);
            bus.rsp_data  = core_q[0].data;
        end else begin
            bus.rsp_valid = 1'b0;
            bus.rsp_data  = '0;
        end
        bus.req_ready     = r_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        bus.m_axis_tready = m_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        #1;

        exp_s_ready   = (phase == PH_LOAD);
        exp_req_valid = (phase == PH_RENDER) && (issued < TOTAL) && (outst < MAXO);
        exp_mvalid    = (phase == PH_RENDER) && bus.rsp_valid;

        check("s_tready",   bus.s_axis_tready, exp_s_ready);
        check("busy",       busy, phase != PH_LOAD);
        check("frame_done", frame_done, phase == PH_DONE);
        check("cfg_err",    cfg_err, err_due);
        check("req_valid",  bus.req_valid, exp_req_valid);
        if (exp_req_valid) begin
            check("req_x", bus.req_x, issued % W);
            check("req_y", bus.req_y, issued / W);
        end
        check("m_tvalid",  bus.m_axis_tvalid, exp_mvalid);
        check("rsp_ready", bus.rsp_ready, (phase == PH_RENDER) && bus.m_axis_tready);
        if (exp_mvalid) begin
            check("m_tdata", bus.m_axis_tdata, bus.rsp_data);
            check("m_tlast", bus.m_axis_tlast, received == TOTAL - 1);
        end else begin
            check("m_tlast_idle", bus.m_axis_tlast, 1'b0);
        end
        check("cfg_data_eq", cfg_data == ref_cfg, 1'b1);

        s_hs   = exp_s_ready && bus.s_axis_tvalid;
        req_hs = exp_req_valid && bus.req_ready;
        out_hs = exp_mvalid && bus.m_axis_tready;

        next     = phase;
        err_next = 1'b0;
        case (phase)
            PH_LOAD: begin
                if (s_hs) begin
                    frame_beats.push_back(bus.s_axis_tdata);
                    if (bus.s_axis_tlast) begin
                        if (frame_beats.size() < SW) begin
                            err_next = 1'b1;
                        end else begin
                            for (int i = 0; i < SW; i++) ref_cfg[i*32 +: 32] = frame_beats[i];
                            next          = PH_RENDER;
                            render_cycles = 0;
                            issued        = 0;
                            received      = 0;
                            outst         = 0;
                            max_outst     = 0;
                        end
                        frame_beats.delete();
                    end
                end
            end
            PH_RENDER: begin
                render_cycles++;
                if (req_hs) begin
                    item.data = {bus.req_y, bus.req_x};
                    item.due  = cyc + core_lat;
                    core_q.push_back(item);
                    issued++;
                end
                if (out_hs) begin
                    check("beat_raster", bus.m_axis_tdata, raster(received));
                    void'(core_q.pop_front());
                    if (received == TOTAL - 1) begin
                        last_beat_data = bus.m_axis_tdata;
                        next           = PH_DONE;
                    end
                    received++;
                end
                outst = outst + int'(req_hs) - int'(out_hs);
                if (outst > max_outst) max_outst = outst;
            end
            default: next = PH_LOAD;
        endcase

        if (s_hs) void'(cfg_src.pop_front());
        cfg_err_pulses += int'(cfg_err);
        done_pulses    += int'(frame_done);
        err_due = err_next;
        phase   = next;
        cyc++;
    endtask

    task automatic push_cfg(input int n, input bit seq);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.data = seq ? 32'(i + 1) : $urandom();
            b.last = (i == n - 1);
            cfg_src.push_back(b);
        end
    endtask

    task automatic run_cfg();
        int guard = 0;
        while (cfg_src.size() > 0 && guard < 200) begin
            step();
            guard++;
        end
        check("cfg_drained", cfg_src.size(), 0);
    endtask

    task automatic run_frame(input int stop_after, input bit full);
        int guard    = 0;
        bit saw_done = 1'b0;
        logic [31:0] exp_perf;
        done_pulses = 0;
        while (guard < 20000) begin
            step();
            guard++;
            if (phase == PH_DONE) saw_done = 1'b1;
            if (saw_done && phase == PH_LOAD) break;
            if (received >= stop_after) break;
        end
        if (full) begin
            check("frame_complete", saw_done && (phase == PH_LOAD), 1'b1);
            check("beat_count", received, TOTAL);
            check("frame_done_pulses", done_pulses, 1);
            check("outst_within_max", max_outst <= MAXO, 1'b1);
`ifdef RT_SCHED_PERF_EN
            exp_perf = 32'(render_cycles);
`else
            exp_perf = 32'h0;
`endif
            check("perf_cycles", perf_cycles, exp_perf);
        end else begin
            check("beats_before_reset", received, stop_after);
        end
    endtask

    task automatic do_reset();
        @(negedge aclk);
        reset             = 1'b1;
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tlast  = 1'b0;
        bus.rsp_valid     = (core_q.size() > 0);
        bus.m_axis_tready = 1'b1;
        bus.req_ready     = 1'b1;
        @(negedge aclk);
        #1;
        check("rst_s_tready",   bus.s_axis_tready, 1'b1);
        check("rst_req_valid",  bus.req_valid, 1'b0);
        check("rst_req_x",      bus.req_x, 16'h0);
        check("rst_req_y",      bus.req_y, 16'h0);
        check("rst_m_tvalid",   bus.m_axis_tvalid, 1'b0);
        check("rst_m_tlast",    bus.m_axis_tlast, 1'b0);
        check("rst_rsp_ready",  bus.rsp_ready, 1'b0);
        check("rst_frame_done", frame_done, 1'b0);
        check("rst_cfg_err",    cfg_err, 1'b0);
        check("rst_busy",       busy, 1'b0);
        check("rst_cfg_zero",   cfg_data == '0, 1'b1);
        check("rst_perf",       perf_cycles, 32'h0);
        @(negedge aclk);
        reset = 1'b0;
        model_clear();
    endtask

    initial begin
        logic [31:0] w0;
        reset             = 1'b1;
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tdata  = '0;
        bus.s_axis_tlast  = 1'b0;
        bus.m_axis_tready = 1'b0;
        bus.req_ready     = 1'b0;
        bus.rsp_valid     = 1'b0;
        bus.rsp_data      = '0;
        cyc            = 0;
        core_lat       = 3;
        m_rand         = 1'b0;
        r_rand         = 1'b0;
        render_cycles  = 0;
        max_outst      = 0;
        cfg_err_pulses = 0;
        done_pulses    = 0;
        last_beat_data = '0;
        model_clear();
        do_reset();

        // Truncated payload: tlast on word 10.
        cfg_err_pulses = 0;
        push_cfg(10, 1'b1);
        run_cfg();
        step();
        step();
        check("early_cfg_err_pulses", cfg_err_pulses, 1);
        check("early_stays_load", busy, 1'b0);
        check("early_cfg_word0", word_of(cfg_data, 0), 32'h0);

        // Full payload 1..27, then a frame with a 3-cycle core.
        cfg_err_pulses = 0;
        push_cfg(SW, 1'b1);
        run_cfg();
        step();
        check("cfg_word0",   word_of(cfg_data, 0), 32'h1);
        check("cfg_word26",  word_of(cfg_data, 26), 32'h1B);
        check("render_next", busy, 1'b1);
        run_frame(TOTAL + 1, 1'b1);
        check("last_beat_value", last_beat_data, 32'h001F001F);
        check("good_cfg_no_err", cfg_err_pulses, 0);

        // Oversized payload (30 beats) with random back-pressure on both sides.
        cfg_err_pulses = 0;
        push_cfg(SW + 3, 1'b0);
        w0 = cfg_src[0].data;
        run_cfg();
        check("ovf_no_err", cfg_err_pulses, 0);
        core_lat = int'($urandom_range(1, 4));
        m_rand   = 1'b1;
        r_rand   = 1'b1;
        step();
        check("ovf_cfg_word0", word_of(cfg_data, 0), w0);
        run_frame(TOTAL + 1, 1'b1);

        // Reset after 500 beats; stale core results must not leak out.
        r_rand   = 1'b0;
        core_lat = 2;
        push_cfg(SW, 1'b0);
        run_cfg();
        run_frame(500, 1'b0);
        do_reset();
        for (int i = 0; i < 5; i++) step();
        core_q.delete();

        // Fresh frame with a next-cycle core, always ready.
        m_rand   = 1'b0;
        core_lat = 1;
        push_cfg(SW, 1'b0);
        run_cfg();
        run_frame(TOTAL + 1, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no end of test, expected completion within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
